// File: rtl/xosera_bus_ctrl_if.sv
// xosera_bus_ctrl_if: host bus pins and register-file port of the bus controller
interface xosera_bus_ctrl_if;
    logic       bus_cs_n_i;
    logic       bus_rd_nwr_i;
    logic       bus_bytesel_i;
    logic [3:0] bus_reg_num_i;
    logic [7:0] bus_data_i;
    logic [7:0] bus_data_o;
    logic       bus_out_ena_o;
    logic       bus_dtack_o;
    logic       reg_wr_o;
    logic       reg_rd_o;
    logic [3:0] reg_num_o;
    logic       reg_bytesel_o;
    logic [7:0] reg_data_o;
    logic [7:0] reg_rd_data_i;
    logic       reg_rd_ack_i;
    logic       rd_timeout_o;
    modport slave (
        input  bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i,
        input  reg_rd_data_i, reg_rd_ack_i,
        output bus_data_o, bus_out_ena_o, bus_dtack_o, reg_wr_o, reg_rd_o,
        output reg_num_o, reg_bytesel_o, reg_data_o, rd_timeout_o
    );
    modport master (
        output bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i,
        output reg_rd_data_i, reg_rd_ack_i,
        input  bus_data_o, bus_out_ena_o, bus_dtack_o, reg_wr_o, reg_rd_o,
        input  reg_num_o, reg_bytesel_o, reg_data_o, rd_timeout_o
    );
endinterface

// File: rtl/xosera_bus_ctrl.sv
// xosera_bus_ctrl: sequences one asynchronous m68k bus cycle into register strobes and DTACK
module xosera_bus_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  reset_i,
    xosera_bus_ctrl_if.slave      bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITE     = 2'd1;
    localparam logic [1:0] READ_WAIT = 2'd2;
    localparam logic [1:0] ACK       = 2'd3;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic       prev_cs_s;
    logic       cs_s;
    logic       cs_fall;
    logic       rd_nwr;
    logic       tmo;
    logic       rd_done;
    logic [1:0] state;
    logic [1:0] state_n;
    logic [7:0] cnt;
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign cs_fall = prev_cs_s & ~cs_s;
    assign tmo     = cnt == 8'(RD_TIMEOUT - 1);
    // a release of CS aborts the read before ack or timeout can complete it
    assign rd_done = state == READ_WAIT && !cs_s && (bus.reg_rd_ack_i || tmo);
    always_comb begin
        state_n = state;
        if (state == IDLE && cs_fall)
            state_n = bus.bus_rd_nwr_i ? READ_WAIT : WRITE;
        else if (state == WRITE)
            state_n = ACK;
        else if (state == READ_WAIT)
            state_n = cs_s ? IDLE : rd_done ? ACK : READ_WAIT;
        else if (state == ACK && cs_s)
            state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state             <= IDLE;
            cs_sync           <= '0;
            prev_cs_s         <= 1'b0;
            rd_nwr            <= 1'b0;
            cnt               <= 8'd0;
            bus.bus_data_o    <= 8'd0;
            bus.bus_out_ena_o <= 1'b0;
            bus.bus_dtack_o   <= 1'b0;
            bus.reg_wr_o      <= 1'b0;
            bus.reg_rd_o      <= 1'b0;
            bus.reg_num_o     <= 4'd0;
            bus.reg_bytesel_o <= 1'b0;
            bus.reg_data_o    <= 8'd0;
            bus.rd_timeout_o  <= 1'b0;
        end else begin
            state     <= state_n;
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.bus_cs_n_i};
            prev_cs_s <= cs_s;
            if (state == IDLE && cs_fall) begin
                rd_nwr            <= bus.bus_rd_nwr_i;
                bus.reg_num_o     <= bus.bus_reg_num_i;
                bus.reg_bytesel_o <= bus.bus_bytesel_i;
                bus.reg_data_o    <= bus.bus_data_i;
            end
            cnt               <= state == READ_WAIT ? cnt + 8'd1 : 8'd0;
            bus.reg_wr_o      <= state_n == WRITE;
            bus.reg_rd_o      <= state_n == READ_WAIT && state != READ_WAIT;
            bus.bus_dtack_o   <= state_n == ACK;
            bus.bus_out_ena_o <= state_n == READ_WAIT || (state_n == ACK && rd_nwr);
            bus.rd_timeout_o  <= rd_done && !bus.reg_rd_ack_i;
            if (rd_done)
                bus.bus_data_o <= bus.reg_rd_ack_i ? bus.reg_rd_data_i : 8'hFF;
        end
    end
endmodule

// File: doc/xosera_bus_ctrl.md
Name: xosera_bus_ctrl

Overview:
- Sequences one asynchronous m68k bus cycle at a time. Owns the flow from the 8-bit bus pins to the internal register file.
- Synchronizes chip-select and latches address, byte select and write data. Issues single-cycle register read/write strobes, waits for read data, then drives DTACK and the data-bus output enable until the host releases CS.
- Sits between the top-level tri-state pad logic and xosera_main's register interface.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on bus_cs_n_i (legal 2..3).
- RD_TIMEOUT, 15, clocks to wait for reg_rd_ack_i before forcing a read response (legal 1..255).

Ports:
- clk  input  1  pixel clock; all logic on posedge.
- reset_i  input  1  synchronous, active-high reset.
- bus_cs_n_i  input  1  async chip select, active low.
- bus_rd_nwr_i  input  1  1=read, 0=write; stable before CS falls.
- bus_bytesel_i  input  1  byte select; stable before CS falls.
- bus_reg_num_i  input  4  register number; stable before CS falls.
- bus_data_i  input  8  write data from pads.
- bus_data_o  output  8  read data to pads, registered.
- bus_out_ena_o  output  1  pad output enable, registered.
- bus_dtack_o  output  1  DTACK, active high; top level inverts it.
- reg_wr_o  output  1  one-cycle write strobe.
- reg_rd_o  output  1  one-cycle read strobe.
- reg_num_o  output  4  latched register number.
- reg_bytesel_o  output  1  latched byte select.
- reg_data_o  output  8  latched write data.
- reg_rd_data_i  input  8  read data from register file.
- reg_rd_ack_i  input  1  read data valid; single cycle.
- rd_timeout_o  output  1  one-cycle pulse when a read times out.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. All synchronizer flops and the previous-CS flop reset to 0 (asserted). A CS held low through reset therefore produces no falling edge and starts no cycle. A cycle begins only after CS is seen high and then low.
- cs_s is the final synchronizer stage. cs_fall = prev_cs_s & ~cs_s.
- Bus pins are latched on the cycle cs_fall is true: reg_num_o, reg_bytesel_o, reg_data_o and the rd_nwr flag. reg_* outputs hold until the next latch.
- State IDLE:
  - cs_fall with write: go to WRITE.
  - cs_fall with read: go to READ_WAIT and clear the counter.
- State WRITE (1 cycle): reg_wr_o=1, then go to ACK.
- State READ_WAIT:
  - reg_rd_o=1 on the first cycle only. bus_out_ena_o=1 while in this state.
  - Ack: reg_rd_ack_i=1 -> bus_data_o<=reg_rd_data_i, go to ACK.
  - Timeout: counter reaches RD_TIMEOUT -> bus_data_o<=8'hFF, rd_timeout_o pulses, go to ACK.
  - Ack and timeout in the same cycle: ack wins, no rd_timeout_o pulse.
  - Abort: cs_s=1 -> go to IDLE with no DTACK. A late ack is ignored.
- State ACK:
  - bus_dtack_o=1. bus_out_ena_o=1 if the cycle is a read.
  - bus_data_o holds its value.
  - Stays until cs_s=1, then goes to IDLE; dtack and out_ena fall on that transition.
- Latency (SYNC_STAGES=N), counted from the first posedge that samples CS low:
  - Strobe (reg_wr_o/reg_rd_o) is high during cycle N+1.
  - Write: bus_dtack_o high from cycle N+2.
  - Read: bus_dtack_o high the cycle after the ack cycle.
  - DTACK low N+1 cycles after the first posedge sampling CS high.
- CS pulse shorter than N clocks: may be missed entirely. No partial strobe is allowed.
- Exactly one strobe per bus cycle. A new cycle is never started from ACK, even if CS glitches low again before cs_s goes high.
- reset_i mid-cycle: state returns to IDLE at once, and all outputs are 0 on the next clock.

Test Plan:
- Write, SYNC_STAGES=2:
  - Stimulus: reg 4'h3, bytesel 1, data 8'hA5, CS low for 10 clocks.
  - Expect: reg_wr_o a single pulse in cycle 3 with reg_num_o=3, reg_bytesel_o=1, reg_data_o=A5.
  - Expect: dtack from cycle 4 until 3 clocks after CS rises. out_ena stays 0 throughout.
- Read with ack:
  - Stimulus: reg 4'h7; ack with data 8'h5C 2 clocks after reg_rd_o.
  - Expect: bus_data_o=5C and dtack=1 the next clock. out_ena=1 from READ_WAIT until CS releases.
- Read timeout, RD_TIMEOUT=15:
  - Stimulus: no ack.
  - Expect: rd_timeout_o a single pulse, bus_data_o=FF, dtack asserted.
  - Expect: a late ack arriving in ACK leaves bus_data_o=FF.
- Aborted read:
  - Stimulus: CS released before ack.
  - Expect: no dtack, state IDLE, a later ack ignored. The next read completes normally.
- Reset with CS held low:
  - Stimulus: assert reset_i during ACK with CS low, then release reset with CS still low.
  - Expect: all outputs 0 and no strobe. Raising then lowering CS produces exactly one strobe.
- Back-to-back cycles:
  - Stimulus: write then read with CS high for exactly 3 clocks between them.
  - Expect: two strobes, correct latched fields, no merged or dropped cycle.
